// File: rtl/wb_regfile.sv
// RV32I writeback register file: 32 x XLEN array, two combinational read ports, load-use scoreboard.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through bypass and early stall release.
module wb_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWEn,
   input  logic [4:0]      addrD,
   input  logic [XLEN-1:0] dataD,
   input  logic [4:0]      addrA,
   input  logic [4:0]      addrB,
   input  logic            useA,
   input  logic            useB,
   output logic [XLEN-1:0] dataA,
   output logic [XLEN-1:0] dataB,
   input  logic            ld_issue,
   input  logic [4:0]      ld_rd,
   output logic            stall,
   output logic [5:0]      busy_cnt
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [5:0]      cnt_nxt;
   logic            wr;
   logic            byp_a;
   logic            byp_b;

   assign wr = RegWEn && (addrD != 5'd0);

   // Clear first, then set, so a new load to the same register wins over the old one's writeback.
   always_comb begin
      busy_nxt = busy;
      if (wr)
         busy_nxt[addrD] = 1'b0;
      if (ld_issue && (ld_rd != 5'd0))
         busy_nxt[ld_rd] = 1'b1;
      cnt_nxt = '0;
      for (int i = 0; i < NREG; i++)
         cnt_nxt = cnt_nxt + 6'(busy_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr)
            regs[addrD] <= dataD;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

`ifdef WB_REGFILE_BYPASS_EN
   assign byp_a = wr && (addrA == addrD);
   assign byp_b = wr && (addrB == addrD);
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   always_comb begin
      dataA = '0;
      dataB = '0;
      if (addrA != 5'd0)
         dataA = byp_a ? dataD : regs[addrA];
      if (addrB != 5'd0)
         dataB = byp_b ? dataD : regs[addrB];
   end

   // A bypassed port already sees the load result, so its hazard term is dropped.
   assign stall = (useA && (addrA != 5'd0) && busy[addrA] && !byp_a) ||
                  (useB && (addrB != 5'd0) && busy[addrB] && !byp_b);

endmodule
